// File: rtl/reg_arb_pkg.sv
// Shared sizing and requester-index type for the register-file write arbiter.
package reg_arb_pkg;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int NREQ = 2;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;

  // Index of the set bit in a one-hot grant vector (0 when empty).
  function automatic req_idx_t oh2idx(input logic [NREQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (oh[i]) idx = req_idx_t'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to ptr.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == req_idx_t'(1)) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges ALU-writeback and load-return writes into one register-file write port.
// Optional REGARB_R0_DISCARD_EN: grants targeting register 0 are consumed without a write.
module reg_write_arbiter #(
  parameter int AW = reg_arb_pkg::AW,
  parameter int DW = reg_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          wen,
  output logic [AW-1:0] wadr,
  output logic [DW-1:0] wdata,
  output logic [1:0]    pending
);
  import reg_arb_pkg::*;

  logic [NREQ-1:0]         vld, rdy, take, full, gnt;
  logic [NREQ-1:0][AW-1:0] in_addr, s_addr;
  logic [NREQ-1:0][DW-1:0] in_data, s_data;
  req_idx_t                ptr, gidx;
  logic                    any_gnt, wr_ok;

  assign vld     = {req1_valid, req0_valid};
  assign in_addr = {req1_addr, req0_addr};
  assign in_data = {req1_data, req0_data};

  rr_arb2 u_arb (
    .req (full),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign any_gnt = |gnt;
  assign gidx    = oh2idx(gnt);

  // A granted slot drains this edge, so it can take a new request at the same time.
  assign rdy  = rst ? '0 : (~full | gnt);
  assign take = vld & rdy;

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign pending    = full;

`ifdef REGARB_R0_DISCARD_EN
  assign wr_ok = any_gnt && (s_addr[gidx] != '0);
`else
  assign wr_ok = any_gnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (take[i]) begin
          full[i]   <= 1'b1;
          s_addr[i] <= in_addr[i];
          s_data[i] <= in_data[i];
        end else if (gnt[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Pointer favours whichever requester was not just served.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (any_gnt) ptr <= ~gidx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen   <= 1'b0;
      wadr  <= '0;
      wdata <= '0;
    end else begin
      wen <= wr_ok;
      if (wr_ok) begin
        wadr  <= s_addr[gidx];
        wdata <= s_data[gidx];
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized + directed bench for reg_write_arbiter against a cycle-level behavioural model.
module tb_reg_write_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          wen;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdata;
  logic [1:0]    pending;

  reg_write_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .wen(wen), .wadr(wadr), .wdata(wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: two holding slots, a "who goes next on a tie" variable,
  // and the registered write port.
  bit            m_full[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  int            m_next;
  bit            m_wen;
  logic [AW-1:0] m_wadr;
  logic [DW-1:0] m_wdata;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int cyc; } wr_t;
  wr_t logq[$];
  int  cyc = 0;

  function automatic bit discard_r0();
`ifdef REGARB_R0_DISCARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int winner();
    if (m_full[0] && m_full[1]) return m_next;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_next = 0; m_wen = 0; m_wadr = '0; m_wdata = '0;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cycle(input bit rr, input bit v0, input bit v1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       output bit took0, output bit took1);
    int w;
    bit e_rdy[2];
    rst = rr; req0_valid = v0; req1_valid = v1;
    req0_addr = a0; req1_addr = a1; req0_data = d0; req1_data = d1;
    @(negedge clk);
    w = winner();
    for (int i = 0; i < 2; i++) e_rdy[i] = !rr && (!m_full[i] || w == i);
    chk("ready0", 32'(req0_ready), 32'(e_rdy[0]));
    chk("ready1", 32'(req1_ready), 32'(e_rdy[1]));
    chk("pending", 32'(pending), {30'd0, 1'(m_full[1]), 1'(m_full[0])});
    chk("wen", 32'(wen), 32'(m_wen));
    chk("wadr", 32'(wadr), 32'(m_wadr));
    chk("wdata", 32'(wdata), 32'(m_wdata));
    if (wen === 1'b1) logq.push_back('{wadr, wdata, cyc});
    took0 = v0 && e_rdy[0];
    took1 = v1 && e_rdy[1];
    @(posedge clk);
    if (rr) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        m_wen = !(discard_r0() && m_addr[w] == '0);
        if (m_wen) begin m_wadr = m_addr[w]; m_wdata = m_data[w]; end
        m_next = 1 - w;
      end else begin
        m_wen = 0;
      end
      if (w >= 0) m_full[w] = 0;
      if (took0) begin m_full[0] = 1; m_addr[0] = a0; m_data[0] = d0; end
      if (took1) begin m_full[1] = 1; m_addr[1] = a1; m_data[1] = d1; end
    end
    cyc++;
    #1;
  endtask

  bit t0, t1;

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, '0, '0, '0, '0, t0, t1);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0, '0, '0, '0, t0, t1);
    cycle(1, 1, 1, 4'hA, 4'hB, 16'hDEAD, 16'hDEAD, t0, t1);
  endtask

  int n0, n1, c0;

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    @(posedge clk); #1;
    model_reset();

    // reset state, ready drops while rst is high
    do_reset();
    chk("rst_wen", 32'(wen), 0);
    chk("rst_pending", 32'(pending), 0);

    // single request, latency
    logq.delete();
    cycle(0, 0, 0, '0, '0, '0, '0, t0, t1);
    chk("post_rst_ready0", 32'(req0_ready), 1);
    c0 = cyc;
    cycle(0, 1, 0, 4'd3, '0, 16'hBEEF, '0, t0, t1);
    idle(3);
    chk("s1_count", 32'(logq.size()), 1);
    if (logq.size() >= 1) begin
      chk("s1_adr", 32'(logq[0].a), 3);
      chk("s1_dat", 32'(logq[0].d), 32'hBEEF);
      chk("s1_lat", 32'(logq[0].cyc), 32'(c0 + 2));
    end
    chk("s1_pending", 32'(pending), 0);

    // simultaneous requests, then confirm pointer is back at 0
    do_reset(); logq.delete();
    cycle(0, 1, 1, 4'd5, 4'd6, 16'h0001, 16'h0002, t0, t1);
    idle(3);
    cycle(0, 1, 1, 4'd7, 4'd8, 16'h0003, 16'h0004, t0, t1);
    idle(3);
    chk("s2_count", 32'(logq.size()), 4);
    if (logq.size() == 4) begin
      chk("s2_w0", 32'(logq[0].a), 5);
      chk("s2_w1", 32'(logq[1].a), 6);
      chk("s2_b2b", 32'(logq[1].cyc - logq[0].cyc), 1);
      chk("s2_ptr0", 32'(logq[2].a), 7);
      chk("s2_w3", 32'(logq[3].a), 8);
    end

    // sustained contention for 8 cycles
    do_reset(); logq.delete();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 1, 4'd1, 4'd2, 16'h1000 + 16'(n0), 16'h2000 + 16'(n1), t0, t1);
      n0 += int'(t0); n1 += int'(t1);
    end
    idle(4);
    chk("s3_count", 32'(logq.size()), 9);
    foreach (logq[j]) begin
      chk("s3_src", 32'(logq[j].a), (j % 2 == 0) ? 1 : 2);
      chk("s3_dat", 32'(logq[j].d), ((j % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(j / 2));
      if (j > 0) chk("s3_gap", 32'(logq[j].cyc - logq[j-1].cyc), 1);
    end

    // reset while slot 1 holds a request
    do_reset(); logq.delete();
    cycle(0, 0, 1, '0, 4'd7, '0, 16'hABCD, t0, t1);
    chk("s4_full", 32'(pending), 2);
    cycle(1, 0, 0, '0, '0, '0, '0, t0, t1);
    chk("s4_wen", 32'(wen), 0);
    chk("s4_pending", 32'(pending), 0);
    idle(4);
    chk("s4_nowrite", 32'(logq.size()), 0);

    // same destination from both requesters
    do_reset(); logq.delete();
    cycle(0, 1, 1, 4'd9, 4'd9, 16'h1111, 16'h2222, t0, t1);
    idle(3);
    chk("s5_count", 32'(logq.size()), 2);
    if (logq.size() == 2) begin
      chk("s5_first", 32'(logq[0].d), 32'h1111);
      chk("s5_last", 32'(logq[1].d), 32'h2222);
      chk("s5_adr", 32'(logq[1].a), 9);
    end

    // register 0 target
    do_reset(); logq.delete();
    cycle(0, 1, 0, 4'd0, '0, 16'hFFFF, '0, t0, t1);
    chk("s6_took", 32'(t0), 1);
    idle(3);
    chk("s6_pending", 32'(pending), 0);
    if (discard_r0()) begin
      chk("s6_count", 32'(logq.size()), 0);
    end else begin
      chk("s6_count", 32'(logq.size()), 1);
      if (logq.size() == 1) begin
        chk("s6_adr", 32'(logq[0].a), 0);
        chk("s6_dat", 32'(logq[0].d), 32'hFFFF);
      end
    end

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
            AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), t0, t1);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have a parameter AW, default 4, giving the register address width (16 registers).
REQ-002 The block SHALL have a parameter DW, default 16, giving the register data width.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock; all state SHALL update on the rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-005 The port req0_valid SHALL be an input, 1 bit wide: requester 0 (ALU writeback) has a write.
REQ-006 The port req0_ready SHALL be an output, 1 bit wide: requester 0's write is accepted this cycle.
REQ-007 The port req0_addr SHALL be an input, AW bits wide: requester 0 destination register.
REQ-008 The port req0_data SHALL be an input, DW bits wide: requester 0 write data.
REQ-009 The ports req1_valid, req1_ready, req1_addr and req1_data SHALL have the same directions and widths as the requester 0 ports and serve requester 1 (load return).
REQ-010 The port wen SHALL be an output, 1 bit wide: write enable to the register file.
REQ-011 The port wadr SHALL be an output, AW bits wide: write address to the register file.
REQ-012 The port wdata SHALL be an output, DW bits wide: write data to the register file.
REQ-013 The port pending SHALL be an output, 2 bits wide: bit i is high while requester i's holding slot is full.

Function
REQ-014 Each requester SHALL own a 1-entry holding slot (addr, data, full flag).
REQ-015 A transfer SHALL occur on requester i when reqi_valid and reqi_ready are both high at a rising edge, loading slot i.
REQ-016 reqi_ready SHALL equal (not slot i full) OR (slot i granted this cycle); it SHALL NOT depend on reqi_valid.
REQ-017 A slot that is granted and reloaded in the same cycle SHALL hold the new request afterwards (full stays 1).
REQ-018 The grant SHALL be combinational over the full flags: if one slot is full, that slot wins; if both are full, the slot indicated by the round-robin pointer wins.
REQ-019 The pointer SHALL reset to requester 0, move to the other requester after every grant, and hold when nothing is granted.
REQ-020 The output register SHALL load wen=1 with the granted slot's addr and data on the edge that ends the grant cycle; with no grant, it SHALL load wen=0 and hold wadr and wdata.
REQ-021 Latency: a request accepted at edge T with no competition SHALL present wen=1 in the cycle following edge T+1.
REQ-022 At most one register-file write SHALL be issued per cycle; sustained throughput SHALL be 1 write per cycle in aggregate.
REQ-023 With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1.
REQ-024 When both slots target the same address, both writes SHALL be issued in grant order; the later-granted data is the final value.

Reset
REQ-025 While rst is high at an edge: both slots SHALL be emptied, any held requests discarded, wen=0, wadr=0, wdata=0, and the pointer set to 0.
REQ-026 reqi_ready SHALL be 0 during any cycle in which rst is high, and no transfer SHALL occur in that cycle.
REQ-027 After rst deasserts, reqi_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 With REGARB_R0_DISCARD_EN defined, a granted slot whose addr is 0 SHALL be consumed normally, but the output register SHALL load wen=0 for it, so register 0 is never written.
REQ-029 Without REGARB_R0_DISCARD_EN defined, address 0 SHALL be treated like every other address.

Structure
REQ-030 A shared package reg_arb_pkg SHALL hold AW, DW, NREQ=2, and the requester-index type.
REQ-031 The two-way round-robin picker SHALL be a sub-module rr_arb2 (inputs: req[1:0], ptr; outputs: one-hot gnt); slots, the pointer and the output register SHALL stay in reg_write_arbiter.

Verification
REQ-032 The bench SHALL cover: reset, then req0 only {addr=3, data=16'hBEEF} accepted at edge T -> wen=1, wadr=3, wdata=16'hBEEF in the cycle after edge T+1; pending=2'b00 afterwards.
REQ-033 The bench SHALL cover: both requesters valid at once, req0 {5, 16'h0001} and req1 {6, 16'h0002} -> writes issue to 5 then 6 on consecutive cycles; the pointer ends at 0.
REQ-034 The bench SHALL cover: both requesters valid for 8 cycles with distinct data -> the write sequence alternates 0,1,... with no gaps and no lost or duplicated data.
REQ-035 The bench SHALL cover: slot 1 full, rst pulsed high for 1 cycle -> wen=0, pending=2'b00, and no write of the discarded data is ever issued.
REQ-036 The bench SHALL cover: both slots targeting address 9 with data 16'h1111 (req0) and 16'h2222 (req1), pointer at 0 -> writes issue in the order 1111, 2222.
REQ-037 The bench SHALL cover: a request {addr=0, data=16'hFFFF} -> with REGARB_R0_DISCARD_EN, req ready but wen stays 0; without it, wen=1 with wadr=0.
